// File: rtl/pipeline_defs.sv
// pipeline_defs: fetch-stage state encodings, reset vector and address helpers.
package pipeline_defs;
    localparam logic [1:0]  FETCH_REQ        = 2'd0;
    localparam logic [1:0]  FETCH_WAIT       = 2'd1;
    localparam logic [1:0]  FETCH_DROP       = 2'd2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction
endpackage

// File: rtl/pipeline_reg.sv
// pipeline_reg: stallable pipeline register; bubble clears it to zero.
module pipeline_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         stall_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       q_o <= '0;
        else if (bubble_i) q_o <= '0;
        else if (!stall_i) q_o <= d_i;
    end
endmodule

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: single-outstanding instruction fetch with a one-entry output slot,
// D-stage back-pressure and redirect flushing.
module pipeline_fetch
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        d_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] t_inst,
    output logic [31:0] t_next_inst_pc,
    output logic [31:0] dbg_t_pc,
    output logic        t_bubble
);
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic        t_valid_q, t_valid_d;
    logic        slot_free, accept, resp_wr;

    always_comb begin
        slot_free = !t_valid_q || !d_stall;
        imem_req  = state_q == FETCH_REQ && slot_free && !redirect;
        accept    = imem_req && imem_ready;
        resp_wr   = state_q == FETCH_WAIT && imem_rvalid && !redirect;
        pc_d      = redirect ? word_align(redirect_pc) : accept ? pc_q + INST_BYTES : pc_q;
        req_pc_d  = accept ? pc_q : req_pc_q;
        t_valid_d = !redirect && (resp_wr || (t_valid_q && d_stall));
        // A redirect with a response still in flight must swallow it in DROP.
        state_d   = redirect ? ((state_q == FETCH_REQ || imem_rvalid) ? FETCH_REQ : FETCH_DROP)
                  : state_q == FETCH_REQ ? (accept ? FETCH_WAIT : FETCH_REQ)
                  : imem_rvalid ? FETCH_REQ : state_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            t_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            t_valid_q <= t_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign t_bubble  = !t_valid_q;

    pipeline_reg #(.W(32)) u_inst (
        .clk(clk), .resetn(resetn), .stall_i(!resp_wr), .bubble_i(1'b0),
        .d_i(imem_rdata), .q_o(t_inst)
    );
    pipeline_reg #(.W(32)) u_next_pc (
        .clk(clk), .resetn(resetn), .stall_i(!resp_wr), .bubble_i(1'b0),
        .d_i(req_pc_q + INST_BYTES), .q_o(t_next_inst_pc)
    );
    pipeline_reg #(.W(32)) u_pc (
        .clk(clk), .resetn(resetn), .stall_i(!resp_wr), .bubble_i(1'b0),
        .d_i(req_pc_q), .q_o(dbg_t_pc)
    );
endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: scoreboard-checked bench with a latency-configurable memory model.
module tb_pipeline_fetch;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] nxt;
    } vec_t;

    logic        clk = 0, resetn = 1, d_stall = 0, redirect = 0;
    logic        imem_ready = 1, imem_rvalid = 0;
    logic [31:0] redirect_pc = 0, imem_rdata = 0;
    logic        imem_req, t_bubble;
    logic [31:0] imem_addr, t_inst, t_next_inst_pc, dbg_t_pc;

    int n_vec = 0, n_err = 0;
    int lat = 1, cnt = 0, cyc = 0, prev, nacc, wt;
    logic        pend = 0, last_acc = 0, last_req = 0;
    logic [31:0] pend_addr = 0, last_addr = 0, exp_a, held_pc, held_inst;
    logic [31:0] exp_q[$];
    vec_t        tbl[4];

    always #5 clk = ~clk;

    pipeline_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn), .d_stall(d_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .t_inst(t_inst), .t_next_inst_pc(t_next_inst_pc), .dbg_t_pc(dbg_t_pc),
        .t_bubble(t_bubble)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: memory drives its response, requests are sampled mid-cycle,
    // the scoreboard is updated at the edge and slot contents are checked at the negedge.
    task automatic cycle();
        logic        rv, rd, wr_chk, drop_chk;
        logic [31:0] a;
        imem_rvalid = pend && cnt == 0;
        imem_rdata  = imem_rvalid ? mdata(pend_addr) : 32'hDEAD_BEEF;
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        last_acc  = imem_req && imem_ready;
        rv = imem_rvalid;
        rd = redirect;
        wr_chk = 0;
        drop_chk = 0;
        a = 0;
        @(posedge clk);
        cyc++;
        if (rd) exp_q.delete();
        if (rv) begin
            pend = 0;
            if (exp_q.size() != 0) begin
                a = exp_q.pop_front();
                wr_chk = 1;
            end else drop_chk = 1;
        end else if (pend) cnt--;
        if (last_acc) begin
            pend = 1;
            cnt = lat - 1;
            pend_addr = last_addr;
            exp_q.push_back(last_addr);
        end
        @(negedge clk);
        if (wr_chk) begin
            chk("slot_valid", t_bubble, 0);
            chk("t_inst", t_inst, mdata(a));
            chk("dbg_t_pc", dbg_t_pc, a);
            chk("t_next_inst_pc", t_next_inst_pc, a + 32'd4);
        end
        if (drop_chk) chk("drop_bubble", t_bubble, 1);
    endtask

    task automatic do_reset(input string tag);
        #3 resetn = 0;
        #1;
        chk({tag, "_rst_bubble"}, t_bubble, 1);
        chk({tag, "_rst_inst"}, t_inst, 0);
        chk({tag, "_rst_dbg_pc"}, dbg_t_pc, 0);
        chk({tag, "_rst_next_pc"}, t_next_inst_pc, 0);
        chk({tag, "_rst_addr"}, imem_addr, RST_PC);
        pend = 0;
        exp_q.delete();
        imem_rvalid = 0;
        redirect = 0;
        d_stall = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    task automatic wait_acc(input string tag);
        int i = 0;
        do begin
            cycle();
            i++;
        end while (!last_acc && i < 30);
        chk({tag, "_acc"}, last_acc, 1);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (t_bubble && i < 30) begin
            cycle();
            i++;
        end
        chk({tag, "_valid"}, t_bubble, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0040_0003, 32'h0040_0000, 32'h0040_0004};
        tbl[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};
        tbl[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'h8000_0000};

        @(negedge clk);
        do_reset("init");

        // back-to-back stream with a 1-cycle memory
        exp_a = RST_PC;
        prev = -1;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_acc) begin
                chk("stream_addr", last_addr, exp_a);
                if (prev >= 0) chk("stream_gap", cyc - prev, 2);
                prev = cyc;
                exp_a += 4;
                nacc++;
            end
        end
        chk("stream_count", nacc, 5);

        // d_stall holds the slot and blocks requests
        wait_valid("stall");
        held_pc = dbg_t_pc;
        held_inst = t_inst;
        d_stall = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req", last_req, 0);
            chk("stall_bubble", t_bubble, 0);
            chk("stall_pc", dbg_t_pc, held_pc);
            chk("stall_inst", t_inst, held_inst);
        end
        d_stall = 0;
        cycle();
        chk("unstall_req", last_req, 1);
        chk("unstall_addr", last_addr, held_pc + 32'd4);
        cycle();

        // request held stable while memory is not ready
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_req", last_req, 1);
            chk("hold_addr", last_addr, held_pc + 32'd8);
        end
        imem_ready = 1;
        cycle();
        chk("hold_acc", last_acc, 1);

        // redirect while waiting on a slow response
        lat = 4;
        wait_acc("rw");
        redirect = 1;
        redirect_pc = 32'h0040_0003;
        cycle();
        chk("rw_req", last_req, 0);
        redirect = 0;
        wt = 0;
        while (pend && wt < 10) begin
            cycle();
            chk("rw_drop_req", last_req, 0);
            wt++;
        end
        lat = 1;
        cycle();
        chk("rw_acc", last_acc, 1);
        chk("rw_addr", last_addr, 32'h0040_0000);

        // redirect coincident with the response
        redirect = 1;
        redirect_pc = 32'h0080_0000;
        cycle();
        chk("rv_req", last_req, 0);
        redirect = 0;
        cycle();
        chk("rv_acc", last_acc, 1);
        chk("rv_addr", last_addr, 32'h0080_0000);
        cycle();

        // redirect while D stalls on a valid slot
        chk("rs_slot", t_bubble, 0);
        d_stall = 1;
        redirect = 1;
        redirect_pc = 32'h00C0_0010;
        cycle();
        chk("rs_bubble", t_bubble, 1);
        chk("rs_req", last_req, 0);
        redirect = 0;
        cycle();
        chk("rs_acc", last_acc, 1);
        chk("rs_addr", last_addr, 32'h00C0_0010);
        d_stall = 0;
        cycle();

        // redirect targets: alignment and PC wrap
        for (int k = 0; k < 4; k++) begin
            redirect = 1;
            redirect_pc = tbl[k].rpc;
            cycle();
            redirect = 0;
            cycle();
            chk("tbl_acc", last_acc, 1);
            chk("tbl_addr", last_addr, tbl[k].addr);
            cycle();
            chk("tbl_next_pc", t_next_inst_pc, tbl[k].nxt);
            cycle();
            chk("tbl_follow", last_addr, tbl[k].nxt);
        end

        // reset while a request is outstanding
        lat = 4;
        wait_acc("rst_wait");
        cycle();
        do_reset("wait");
        lat = 1;
        cycle();
        chk("wait_rel_acc", last_acc, 1);
        chk("wait_rel_addr", last_addr, RST_PC);
        cycle();

        // reset while dropping a response
        lat = 4;
        wait_acc("rst_drop");
        redirect = 1;
        redirect_pc = 32'h0000_1000;
        cycle();
        redirect = 0;
        do_reset("drop");
        lat = 1;
        cycle();
        chk("drop_rel_acc", last_acc, 1);
        chk("drop_rel_addr", last_addr, RST_PC);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
